registrador: RTL and testbench

- Parameterisable load-enable data register; default width 16 bits.
- Captures input word `a` on the rising clock edge when `load` is asserted, otherwise holds its value.
- Stored value is continuously presented on `leitura`.
- General-purpose storage element for datapath operand/result holding; adds byte-lane write masking, synchronous clear and a "written" status flag.

---
 rtl/registrador.sv | 52 +++++
 tb/tb_registrador.sv | 127 ++++++++++++
 2 files changed

// File: rtl/registrador.sv
// Load-enable data register with byte-lane write mask, synchronous clear
// and a sticky "written" flag that is cleared only by reset or clr.
module registrador #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH/8-1:0] byte_en,
   input  logic               clr,
   output logic [WIDTH-1:0]   leitura,
   output logic               written
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] leitura_q, leitura_d;
   logic             written_q, written_d;

   // clr outranks load; a load with an all-zero mask still marks the register written
   always_comb begin
      leitura_d = leitura_q;
      written_d = written_q;
      if (clr) begin
         leitura_d = RESET_VALUE;
         written_d = 1'b0;
      end else if (load) begin
         for (int i = 0; i < NB; i++) begin
            if (byte_en[i]) begin
               leitura_d[8*i +: 8] = a[8*i +: 8];
            end
         end
         written_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         leitura_q <= RESET_VALUE;
         written_q <= 1'b0;
      end else begin
         leitura_q <= leitura_d;
         written_q <= written_d;
      end
   end

   assign leitura = leitura_q;
   assign written = written_q;

endmodule

// File: tb/tb_registrador.sv
// Directed self-checking bench for registrador: vector table plus hand-written
// sequences for asynchronous reset and a second instance with RESET_VALUE=16'h00FF.
module tb_registrador;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] a;
   logic [1:0]  byte_en;
   logic        clr;
   logic [15:0] leitura;
   logic        written;
   logic [15:0] leitura2;
   logic        written2;

   int checks = 0;
   int errors = 0;

   registrador #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
      .clk(clk), .reset(reset), .load(load), .a(a), .byte_en(byte_en),
      .clr(clr), .leitura(leitura), .written(written)
   );

   registrador #(.WIDTH(16), .RESET_VALUE(16'h00FF)) dut_ff (
      .clk(clk), .reset(reset), .load(load), .a(a), .byte_en(byte_en),
      .clr(clr), .leitura(leitura2), .written(written2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        clr;
      logic        load;
      logic [1:0]  be;
      logic [15:0] a;
      logic [15:0] exp_q;
      logic        exp_w;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // apply inputs on the falling edge, sample 1 time unit after the rising edge
   task automatic step(input logic c, input logic l, input logic [1:0] be, input logic [15:0] d);
      @(negedge clk);
      clr = c; load = l; byte_en = be; a = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            clr   load  be     a         exp_q     exp_w
      vecs[0]  = '{1'b0, 1'b1, 2'b11, 16'd32,   16'd32,   1'b1};
      vecs[1]  = '{1'b0, 1'b1, 2'b11, 16'd85,   16'd85,   1'b1};
      vecs[2]  = '{1'b0, 1'b0, 2'b11, 16'd74,   16'd85,   1'b1};
      vecs[3]  = '{1'b0, 1'b1, 2'b11, 16'd42,   16'd42,   1'b1};
      vecs[4]  = '{1'b1, 1'b1, 2'b11, 16'd99,   16'd0,    1'b0};
      vecs[5]  = '{1'b0, 1'b1, 2'b11, 16'd99,   16'd99,   1'b1};
      vecs[6]  = '{1'b0, 1'b1, 2'b11, 16'hABCD, 16'hABCD, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 2'b01, 16'h1234, 16'hAB34, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 2'b10, 16'h5678, 16'h5634, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 2'b00, 16'hFFFF, 16'h0000, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 2'b11, 16'h1111, 16'h0000, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 2'b11, 16'hBEEF, 16'hBEEF, 1'b1};

      reset = 1'b1; load = 1'b0; clr = 1'b0; byte_en = 2'b11; a = 16'h0000;
      #1;
      check("reset_leitura", {16'h0, leitura}, 32'h0);
      check("reset_written", {31'h0, written}, 32'h0);
      check("reset_leitura_ff", {16'h0, leitura2}, 32'h00FF);
      check("reset_written_ff", {31'h0, written2}, 32'h0);

      // load held high across an edge while reset is asserted
      load = 1'b1; a = 16'h0055;
      @(posedge clk); #1;
      check("reset_hold_leitura", {16'h0, leitura}, 32'h0);
      check("reset_hold_written", {31'h0, written}, 32'h0);

      @(negedge clk);
      reset = 1'b0; load = 1'b0;

      for (int i = 0; i < 13; i++) begin
         step(vecs[i].clr, vecs[i].load, vecs[i].be, vecs[i].a);
         check($sformatf("vec%0d_leitura", i), {16'h0, leitura}, {16'h0, vecs[i].exp_q});
         check($sformatf("vec%0d_written", i), {31'h0, written}, {31'h0, vecs[i].exp_w});
         if (vecs[i].clr) begin
            check($sformatf("vec%0d_clr_ff", i), {16'h0, leitura2}, 32'h00FF);
            check($sformatf("vec%0d_clr_wr_ff", i), {31'h0, written2}, 32'h0);
         end
      end

      // async reset pulse between edges, with load=1 a=7 already set up
      step(1'b0, 1'b1, 2'b11, 16'd85);
      check("pre_async_leitura", {16'h0, leitura}, 32'd85);
      @(negedge clk);
      load = 1'b1; a = 16'd7;
      #2 reset = 1'b1;
      #1;
      check("async_leitura", {16'h0, leitura}, 32'h0);
      check("async_written", {31'h0, written}, 32'h0);
      check("async_leitura_ff", {16'h0, leitura2}, 32'h00FF);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check("post_async_leitura", {16'h0, leitura}, 32'd7);
      check("post_async_written", {31'h0, written}, 32'h1);

      // back-to-back loads on consecutive edges
      step(1'b0, 1'b1, 2'b11, 16'h0101);
      check("b2b_first", {16'h0, leitura}, 32'h0101);
      step(1'b0, 1'b1, 2'b11, 16'h0202);
      check("b2b_second", {16'h0, leitura}, 32'h0202);
      check("b2b_ff", {16'h0, leitura2}, 32'h0202);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
